// File: rtl/fp16_to_int.sv
// Purpose: converts an IEEE-754 binary16 operand to a saturating signed 16-bit integer.
// Latency: the result is valid after 1+n edges, counting the accepting edge, where
//          n = |E-25| for 15<=E<=30 and n = 0 for Inf/NaN, zero, denormals and |x|<1.
// Backpressure: one request in flight; ready is high only in IDLE, and the result is
//               held in DONE until ready_i is seen.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   valid_i, ready_o,      request handshake and binary16 operand {sign, exp[4:0], frac[9:0]}
//   opA_i
//   valid_o, ready_i       result handshake
//   INT_o, ovf_o,          two's-complement result, saturation flag, and a flag that
//   inexact_o              nonzero fraction bits were discarded
//
// Build option: define FP2INT_RNE_EN for round-to-nearest-even; otherwise the
// conversion truncates toward zero.

module fp16_to_int (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] opA_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] INT_o,
    output logic        ovf_o,
    output logic        inexact_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;

    // Datapath registers
    logic        sign_q,   sign_nxt;
    logic [16:0] mag_q,    mag_nxt;
    logic        guard_q,  guard_nxt;
    logic        sticky_q, sticky_nxt;
    logic [3:0]  n_q,      n_nxt;
    logic        left_q,   left_nxt;

    // Result registers, loaded only on the edge that enters DONE
    logic [15:0] int_q,    int_nxt;
    logic        ovf_q,    ovf_nxt;
    logic        inx_q,    inx_nxt;

    // Operand fields
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [9:0]  in_frac;

    assign in_sign = opA_i[15];
    assign in_exp  = opA_i[14:10];
    assign in_frac = opA_i[9:0];

    // Rounding, saturation and negation of a finished magnitude.
    // Returns {int[15:0], ovf, inexact}.
    function automatic logic [17:0] finish_result(
        input logic        s,
        input logic [16:0] m,
        input logic        g,
        input logic        st
    );
        logic [16:0] mr;
        logic [15:0] r_int;
        logic        r_ovf;
        logic        r_inx;
        mr    = m;
`ifdef FP2INT_RNE_EN
        // Round up when above half, or exactly half and the kept LSB is odd.
        if (g && (st || m[0])) begin
            mr = m + 17'd1;
        end
`endif
        r_inx = g | st;
        r_ovf = 1'b0;
        if ((!s && (mr > 17'd32767)) || (s && (mr > 17'd32768))) begin
            r_int = s ? 16'h8000 : 16'h7FFF;
            r_ovf = 1'b1;
            r_inx = 1'b0;
        end else if (s) begin
            r_int = ~mr[15:0] + 16'd1;
        end else begin
            r_int = mr[15:0];
        end
        return {r_int, r_ovf, r_inx};
    endfunction

    // Next-state and datapath logic
    always_comb begin
        state_nxt  = state;
        sign_nxt   = sign_q;
        mag_nxt    = mag_q;
        guard_nxt  = guard_q;
        sticky_nxt = sticky_q;
        n_nxt      = n_q;
        left_nxt   = left_q;
        int_nxt    = int_q;
        ovf_nxt    = ovf_q;
        inx_nxt    = inx_q;

        unique case (state)
            IDLE: begin
                if (valid_i) begin
                    sign_nxt   = in_sign;
                    mag_nxt    = {6'd0, (in_exp != 5'd0), in_frac};
                    guard_nxt  = 1'b0;
                    sticky_nxt = 1'b0;
                    n_nxt      = 4'd0;
                    left_nxt   = 1'b0;
                    if (in_exp == 5'd31) begin
                        // Inf/NaN: NaN saturates positive regardless of sign.
                        state_nxt = DONE;
                        int_nxt   = (in_sign && (in_frac == 10'd0)) ? 16'h8000 : 16'h7FFF;
                        ovf_nxt   = 1'b1;
                        inx_nxt   = 1'b0;
                    end else if (in_exp < 5'd15) begin
                        // |x| < 1: integer part is zero; any nonzero encoding is inexact.
                        state_nxt = DONE;
                        int_nxt   = 16'h0000;
                        ovf_nxt   = 1'b0;
                        inx_nxt   = (in_exp != 5'd0) || (in_frac != 10'd0);
`ifdef FP2INT_RNE_EN
                        // [0.5,1): exactly 0.5 ties to even zero, anything above rounds to 1.
                        if ((in_exp == 5'd14) && (in_frac != 10'd0)) begin
                            int_nxt = in_sign ? 16'hFFFF : 16'h0001;
                        end
`endif
                    end else begin
                        // Binary point sits 10 bits into M; e=E-15 moves it by e-10 = E-25.
                        if (in_exp <= 5'd25) begin
                            n_nxt    = 4'(5'd25 - in_exp);
                            left_nxt = 1'b0;
                        end else begin
                            n_nxt    = 4'(in_exp - 5'd25);
                            left_nxt = 1'b1;
                        end
                        if (in_exp == 5'd25) begin
                            state_nxt = DONE;
                            {int_nxt, ovf_nxt, inx_nxt} =
                                finish_result(in_sign, mag_nxt, 1'b0, 1'b0);
                        end else begin
                            state_nxt = SHIFT;
                        end
                    end
                end
            end

            SHIFT: begin
                if (left_q) begin
                    mag_nxt = {mag_q[15:0], 1'b0};
                end else begin
                    // Bits leave through guard, then accumulate into sticky.
                    mag_nxt    = {1'b0, mag_q[16:1]};
                    guard_nxt  = mag_q[0];
                    sticky_nxt = sticky_q | guard_q;
                end
                n_nxt = n_q - 4'd1;
                if (n_q == 4'd1) begin
                    state_nxt = DONE;
                    {int_nxt, ovf_nxt, inx_nxt} =
                        finish_result(sign_q, mag_nxt, guard_nxt, sticky_nxt);
                end
            end

            DONE: begin
                if (ready_i) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= 17'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            n_q      <= 4'd0;
            left_q   <= 1'b0;
            int_q    <= 16'h0000;
            ovf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sign_q   <= sign_nxt;
            mag_q    <= mag_nxt;
            guard_q  <= guard_nxt;
            sticky_q <= sticky_nxt;
            n_q      <= n_nxt;
            left_q   <= left_nxt;
            int_q    <= int_nxt;
            ovf_q    <= ovf_nxt;
            inx_q    <= inx_nxt;
        end
    end

    assign ready_o   = (state == IDLE);
    assign valid_o   = (state == DONE);
    assign INT_o     = int_q;
    assign ovf_o     = ovf_q;
    assign inexact_o = inx_q;

endmodule
